// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage: stage payload layouts
// and pointer sizing helpers.
package pipe_stage_elastic_pkg;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // MEM/WB payload: writeback target plus the values the WB stage selects from.
  typedef struct packed {
    logic [4:0]  rd;
    logic        wreg;
    logic        mem2reg;
    logic [31:0] from_alu;
    logic [2:0]  func3;
    logic [31:0] pc;
  } mem_wb_pl_t;

  // EX/MEM payload: ALU result, store data and memory access controls.
  typedef struct packed {
    logic [4:0]  rd;
    logic        wreg;
    logic        mem2reg;
    logic        mem_we;
    logic [31:0] from_alu;
    logic [31:0] store_data;
    logic [2:0]  func3;
    logic [31:0] pc;
  } ex_mem_pl_t;

  // ID/EX payload: decoded operands and controls for the execute stage.
  typedef struct packed {
    logic [4:0]  rd;
    logic        wreg;
    logic        mem2reg;
    logic        mem_we;
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic [2:0]  func3;
    logic [31:0] pc;
  } id_ex_pl_t;

  // Pointer width for a circular buffer of the given depth (at least 1 bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return (depth > 0) ? $clog2(depth + 1) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_ram.sv
// DEPTH x DATA_W register array with one write port and one asynchronous
// read port. Contents are cleared by reset so nothing undefined ever reaches
// the read port.
module pipe_stage_ram
  import pipe_stage_elastic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int AW     = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Next array contents: only the addressed slot changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage registers, cleared on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register holding up to DEPTH entries in a
// circular buffer. Flush discards everything held plus this cycle's push and
// pop; an empty stage presents zero payload when ZERO_WHEN_EMPTY is set.
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int DEPTH           = 2,
  parameter bit READY_PASS      = 1'b1,
  parameter bit ZERO_WHEN_EMPTY = 1'b1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic              full;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] rd_data;

  assign full = (count_q == FULL_CNT);

  // Ready is occupancy-only unless pass-through lets a full stage accept
  // when the head is leaving in the same cycle.
  always_comb begin
    in_ready = ~full;
    if (READY_PASS) begin
      in_ready = ~full | out_ready;
    end
  end

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid_q & out_ready & ~flush;

  // Pointer, occupancy and valid next-state; flush returns everything to empty.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + ONE_CNT;
      end else if (pop && !push) begin
        count_d = count_q - ONE_CNT;
      end
    end
    out_valid_d = (count_d != '0);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  // When full with a simultaneous pop, wr_ptr equals rd_ptr, so the write
  // lands in the slot being vacated while the old head is still read out.
  pipe_stage_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PTR_W)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Head payload, optionally masked so stale storage never shows when empty.
  always_comb begin
    out_data = rd_data;
    if (ZERO_WHEN_EMPTY && !out_valid_q) begin
      out_data = '0;
    end
  end

  assign out_valid = out_valid_q;
  assign count     = count_q;

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline register that replaces the fixed-payload stall/flush stage registers (MEM/WB first, then ID/EX and EX/MEM) with a valid/ready stage carrying a generic payload. It buffers up to `DEPTH` entries so an upstream stage can keep issuing while the downstream stage is busy. It drops all held entries on flush and presents zero payload when empty. It sits between any two CPU pipeline stages; the stage-specific fields are packed into `in_data` by the instantiating stage.

## Interface
- `DATA_W`, 32: payload width in bits; must be ≥1.
- `DEPTH`, 2: entries held; must be ≥1. `DEPTH=1` is a plain pipeline register.
- `READY_PASS`, 1: when 1, `in_ready` is also asserted while full if `out_ready=1`, which gives a combinational ready path. When 0, `in_ready` depends only on occupancy.
- `ZERO_WHEN_EMPTY`, 1: when 1, `out_data` is forced to all-zero while `out_valid=0`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rstn`, in, 1: asynchronous, active-low reset.
- `flush`, in, 1: synchronous discard of all held entries and of this cycle's push.
- `in_valid`, in, 1: upstream offers `in_data`.
- `in_ready`, out, 1: stage accepts this cycle.
- `in_data`, in, `DATA_W`: payload.
- `out_valid`, out, 1: head entry is valid.
- `out_ready`, in, 1: downstream consumes the head this cycle.
- `out_data`, out, `DATA_W`: head payload.
- `count`, out, `$clog2(DEPTH+1)`: current occupancy.

## Operation
- push = `in_valid & in_ready & ~flush`.
- pop = `out_valid & out_ready & ~flush`.
- Storage is a circular buffer with write and read pointers of width `$clog2(DEPTH)` (1 bit minimum). Each pointer advances on its event and wraps from `DEPTH-1` to 0.
- `count` next value:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- `out_valid` = `count != 0`. `out_data` = `mem[rd_ptr]`, or 0 per `ZERO_WHEN_EMPTY`.
- `in_ready`:
  - `READY_PASS=0`: `count < DEPTH`.
  - `READY_PASS=1`: `(count < DEPTH) | out_ready`.
- Full and push+pop in the same cycle (`READY_PASS=1` only): the write targets the slot being freed and `count` stays at `DEPTH`.
- Empty: pop cannot occur. A push makes the entry visible the next cycle; there is no same-cycle bypass.
- Flush:
  - Next cycle `count=0`, both pointers = 0, `out_valid=0`.
  - Storage contents may remain but must not be visible when `ZERO_WHEN_EMPTY=1`.
  - Flush wins over a simultaneous push and a simultaneous pop; neither takes effect.
- Payload is never modified, reordered or duplicated. Ordering is strict FIFO.
- Legacy stall mapping used by the CPU top:
  - `out_ready = ~stall[downstream]`.
  - `in_valid` = upstream not stalled.
  - Upstream stalled while downstream runs drains the stage, which replaces bubble insertion.

## Timing
- Reset (async assert, sync-safe deassert): `count=0`, pointers 0, `out_valid=0`, `out_data=0`, `in_ready=1`. Storage is cleared to 0.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency: push in cycle N makes the data visible at `out_*` in cycle N+1.
- Throughput: one transfer per cycle at `DEPTH≥2`, or at `DEPTH=1` with `READY_PASS=1`. At `DEPTH=1` with `READY_PASS=0`, the maximum rate is one transfer per 2 cycles.
- `out_valid`, `out_data` and `count` are register-driven. `in_ready` is registered-only when `READY_PASS=0`.
- `in_data` is sampled only on push; its value at other times is don't-care.

## Structure
- `cpu_pkg` additions:
  - `ZeroWord` reuse.
  - Stage payload typedefs: packed structs `mem_wb_pl_t` (`rd`, `wreg`, `mem2reg`, `from_alu`, `func3`, `pc`) and similar for the other stages, used to set `DATA_W` via `$bits`.
- Optional sub-module `pipe_stage_ram`: `DEPTH`×`DATA_W` register array with a write port and an async read port. The pointers, count and handshake logic stay in `pipe_stage_elastic`.

## Test plan
- **Reset:** hold `rstn=0`, drive `in_valid=1` with `in_data=0xDEADBEEF` → `out_valid=0`, `out_data=0`, `count=0`, `in_ready=1`. Release reset; the first push appears 1 cycle later.
- **Fill/full:** `DEPTH=2`, `READY_PASS=0`, `out_ready=0`, push 0x11 and 0x22 → `count=2`, `in_ready=0`. A third offer of 0x33 is ignored. Then `out_ready=1` → outputs 0x11 then 0x22, `count` goes to 0.
- **Full pass-through:** `DEPTH=2`, `READY_PASS=1`, full with 0xA then 0xB, push 0xC with `out_ready=1` in the same cycle → `count` stays 2. Output sequence 0xA, 0xB, 0xC with pointer wrap.
- **Flush priority:** `count=1` holding 0x55. Assert `flush`, `in_valid` with 0x66 and `out_ready` together → next cycle `count=0`, `out_valid=0`, `out_data=0`. The subsequent output stream has neither 0x55 nor 0x66.
- **Streaming:** `DEPTH=1`, `READY_PASS=1`, continuous valid and ready with 0..99 → 100 outputs in order at one per cycle, with first output 1 cycle after the first push.
- **Async reset mid-stream:** `count=2`, pulse `rstn` low between clock edges → `out_valid` drops before the next edge, `count=0`, no stale data after release.
